carrier_buf: RTL and testbench

CARRIER_BUF -- requirements
Module: carrier_buf

---
 rtl/carrier_buf_pkg.sv | 21 ++
 rtl/carrier_buf_ram.sv | 29 ++
 rtl/carrier_buf.sv | 143 ++++++++++++++
 tb/tb_carrier_buf.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/carrier_buf_pkg.sv
// Shared OFDM RX constants for the carrier buffer.
// Holds the default FFT size, used-carrier split and buffer depth, plus a
// constant clog2 helper used to size pointers, counters and ports.
package carrier_buf_pkg;

  localparam int CB_NFFT  = 256;
  localparam int CB_LO_N  = 100;
  localparam int CB_HI_N  = 100;
  localparam int CB_DEPTH = 200;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/carrier_buf_ram.sv
// cb_ram: simple dual-port storage for the carrier buffer.
// Ports: clk; we/waddr/wdat write port; re/raddr read port with a
// registered rdat (one-cycle latency, holds when re is low).
// A read and a write to the same address in one cycle return the old data.
// No reset: contents survive rst and start.
module cb_ram
  import carrier_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = CB_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdat,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
    if (re) rdat <= mem[raddr];
  end

endmodule

// File: rtl/carrier_buf.sv
// carrier_buf: keeps only the used OFDM carriers of each FFT symbol
// (bins 0..LO_N-1 and NFFT-HI_N..NFFT-1) in a circular buffer that the
// consumer reads at an offset from the oldest entry and frees in order.
// Ports:
//   clk, rst (async, active-high), start (sync clear of pointers/flags)
//   in_valid/in_sof/in_dat  : FFT bin stream, in_sof marks bin 0
//   in_ready                : room for at least one more entry
//   rd_en/rd_off            : read oldest+rd_off, rd_dat/rd_valid next cycle
//   rd_free                 : release oldest entry
//   count/almost_full/full  : occupancy status
//   sym_done                : pulse after last used carrier of a symbol is stored
//   overflow                : sticky, a used carrier was dropped while full
module carrier_buf
  import carrier_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NFFT   = CB_NFFT,
  parameter int LO_N   = CB_LO_N,
  parameter int HI_N   = CB_HI_N,
  parameter int DEPTH  = CB_DEPTH,
  parameter int AF_LVL = 180
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          in_dat,
  output logic                       in_ready,
  input  logic                       rd_en,
  input  logic [clog2(DEPTH)-1:0]    rd_off,
  output logic [DATA_W-1:0]          rd_dat,
  output logic                       rd_valid,
  input  logic                       rd_free,
  output logic [clog2(DEPTH+1)-1:0]  count,
  output logic                       almost_full,
  output logic                       full,
  output logic                       sym_done,
  output logic                       overflow
);

  localparam int AW         = clog2(DEPTH);
  localparam int CW         = clog2(DEPTH + 1);
  localparam int BW         = clog2(NFFT);
  localparam int HI_START   = NFFT - HI_N;
  localparam int LAST_BIN   = (HI_N == 0) ? LO_N - 1 : NFFT - 1;
  localparam int DEPTH_LAST = DEPTH - 1;

  localparam logic [BW:0]   LO_B     = LO_N[BW:0];
  localparam logic [BW:0]   HI_B     = HI_START[BW:0];
  localparam logic [BW-1:0] LAST_B   = LAST_BIN[BW-1:0];
  localparam logic [AW-1:0] PTR_LAST = DEPTH_LAST[AW-1:0];
  localparam logic [AW:0]   DEPTH_A  = DEPTH[AW:0];
  localparam logic [CW-1:0] DEPTH_C  = DEPTH[CW-1:0];
  localparam logic [CW-1:0] AF_C     = AF_LVL[CW-1:0];

  logic [BW-1:0]     bcnt;
  logic [BW-1:0]     cur_bin;
  logic              used;
  logic              wr;
  logic              drop;
  logic              fr;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       rd_sum;
  logic [AW-1:0]     rd_addr;
  logic              rd_re;
  logic              rd_hold;
  logic [DATA_W-1:0] ram_q;

  always_comb begin
    cur_bin = in_sof ? '0 : bcnt;
    used    = ({1'b0, cur_bin} < LO_B) || ({1'b0, cur_bin} >= HI_B);
    wr      = in_valid & used & ~full & ~start;
    drop    = in_valid & used & full & ~start;
    fr      = rd_free & (count != '0) & ~start;
    rd_sum  = {1'b0, rd_ptr} + {1'b0, rd_off};
    rd_addr = (rd_sum >= DEPTH_A) ? AW'(rd_sum - DEPTH_A) : AW'(rd_sum);
    rd_re   = rd_en & ~start;
  end

  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AF_C);
  assign in_ready    = (count < DEPTH_C);

  // Control state: start has priority over every other input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      sym_done <= 1'b0;
      rd_valid <= 1'b0;
    end else if (start) begin
      bcnt     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      sym_done <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      // NFFT is a power of two, so the bin counter wraps on its own.
      if (in_valid) bcnt <= cur_bin + 1'b1;
      if (wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (fr) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr, fr})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      sym_done <= wr & (cur_bin == LAST_B);
      rd_valid <= rd_en;
    end
  end

  // The RAM read register has no reset; rd_dat reads as zero until the
  // first read after rst, then holds the last value read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_hold <= 1'b0;
    else if (rd_re) rd_hold <= 1'b1;
  end

  assign rd_dat = rd_hold ? ram_q : '0;

  cb_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr),
    .wdat  (in_dat),
    .re    (rd_re),
    .raddr (rd_addr),
    .rdat  (ram_q)
  );

endmodule

// File: tb/tb_carrier_buf.sv
// Directed bench for carrier_buf with default parameters (NFFT=256,
// LO_N=HI_N=100, DEPTH=200, AF_LVL=180). Sample data is {symbol, bin}.
module tb_carrier_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [31:0] in_dat = '0;
  logic        in_ready;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_off = '0;
  logic [31:0] rd_dat;
  logic        rd_valid;
  logic        rd_free = 1'b0;
  logic [7:0]  count;
  logic        almost_full;
  logic        full;
  logic        sym_done;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int sd;
  int p;

  always #5 clk = ~clk;

  carrier_buf dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_dat      (in_dat),
    .in_ready    (in_ready),
    .rd_en       (rd_en),
    .rd_off      (rd_off),
    .rd_dat      (rd_dat),
    .rd_valid    (rd_valid),
    .rd_free     (rd_free),
    .count       (count),
    .almost_full (almost_full),
    .full        (full),
    .sym_done    (sym_done),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sof, input logic [31:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_dat   = d;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    rd_en  = 1'b1;
    rd_off = off;
    tick();
    rd_en  = 1'b0;
    check({tag, "_vld"}, rd_valid, 1);
    check(tag, rd_dat, exp);
  endtask

  // Expected buffered entry: index 0..99 -> bins 0..99, 100..199 -> bins 156..255.
  function automatic logic [31:0] ent(input int sym, input int idx);
    int b;
    b = (idx < 100) ? idx : idx + 56;
    return {sym[15:0], b[15:0]};
  endfunction

  task automatic send_sym(input int sym, output int pulses);
    pulses = 0;
    for (int b = 0; b < 256; b++) begin
      send(b == 0, {sym[15:0], b[15:0]});
      if (sym_done) pulses++;
    end
    tick();
    if (sym_done) pulses++;
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ready", in_ready, 1);
    check("rst_rdvld", rd_valid, 0);
    check("rst_rddat", rd_dat, 0);
    check("rst_symdone", sym_done, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    // Symbol 1: occupancy thresholds and sym_done timing
    sd = 0;
    for (int b = 0; b < 256; b++) begin
      send(b == 0, {16'h0001, b[15:0]});
      if (b < 255 && sym_done) sd++;
      if (b == 99)  check("cnt_b99", count, 100);
      if (b == 155) check("cnt_b155", count, 100);
      if (b == 234) check("af_179", almost_full, 0);
      if (b == 235) begin
        check("af_180", almost_full, 1);
        check("full_180", full, 0);
      end
      if (b == 254) check("full_199", full, 0);
      if (b == 255) begin
        check("sd_pulse", sym_done, 1);
        check("cnt_200", count, 200);
        check("full_200", full, 1);
        check("ready_200", in_ready, 0);
        check("ovf_200", overflow, 0);
      end
    end
    tick();
    check("sd_clear", sym_done, 0);
    check("sd_early", sd, 0);

    read_chk("rd_off0", 8'd0, ent(1, 0));
    read_chk("rd_off5", 8'd5, ent(1, 5));
    read_chk("rd_off99", 8'd99, ent(1, 99));
    read_chk("rd_off100", 8'd100, ent(1, 100));
    read_chk("rd_off199", 8'd199, ent(1, 199));
    tick();
    check("rdvld_drop", rd_valid, 0);

    // Symbol 2 with no frees: everything dropped
    send_sym(2, p);
    check("ovf_sym2", overflow, 1);
    check("cnt_sym2", count, 200);
    check("sd_sym2", p, 0);

    // Write and free together while full: write dropped, count decrements
    rd_free = 1'b1;
    send(1'b1, 32'h0003_0000);
    rd_free = 1'b0;
    check("wrfr_full_cnt", count, 199);
    read_chk("wrfr_full_old", 8'd0, ent(1, 1));

    rd_free = 1'b1;
    repeat (49) tick();
    rd_free = 1'b0;
    check("cnt_150", count, 150);
    read_chk("free50_old", 8'd0, ent(1, 50));

    // Refill: wr_ptr continues from 0 after the 199 -> 0 wrap
    for (int b = 1; b <= 50; b++) send(1'b0, {16'h0003, b[15:0]});
    check("cnt_refill", count, 200);
    check("full_refill", full, 1);
    read_chk("wrap_199", 8'd149, ent(1, 199));
    read_chk("wrap_0", 8'd150, 32'h0003_0001);
    read_chk("wrap_49", 8'd199, 32'h0003_0032);

    rd_free = 1'b1;
    repeat (80) tick();
    rd_free = 1'b0;
    check("cnt_120", count, 120);
    read_chk("free130_old", 8'd0, ent(1, 130));

    // Write and free together at count 120
    rd_free = 1'b1;
    send(1'b0, 32'h0003_0033);
    rd_free = 1'b0;
    check("wrfr_120_cnt", count, 120);
    read_chk("wrfr_120_dat", 8'd119, 32'h0003_0033);

    // Asynchronous reset in the middle of a symbol
    for (int b = 52; b <= 54; b++) send(1'b0, {16'h0003, b[15:0]});
    rd_en    = 1'b1;
    rd_off   = 8'd0;
    in_valid = 1'b1;
    in_dat   = 32'h0003_0037;
    tick();
    in_valid = 1'b0;
    rd_en    = 1'b0;
    check("pre_rst_rdvld", rd_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_full", full, 0);
    check("arst_af", almost_full, 0);
    check("arst_ready", in_ready, 1);
    check("arst_rdvld", rd_valid, 0);
    check("arst_rddat", rd_dat, 0);
    check("arst_symdone", sym_done, 0);
    check("arst_ovf", overflow, 0);
    tick();
    rst = 1'b0;

    // Resume without in_sof: bin counter must restart at 0
    for (int b = 0; b <= 100; b++) send(1'b0, {16'h0004, b[15:0]});
    check("resume_cnt", count, 100);
    read_chk("resume_first", 8'd0, 32'h0004_0000);
    read_chk("resume_last", 8'd99, 32'h0004_0063);

    for (int b = 101; b <= 255; b++) send(1'b0, {16'h0004, b[15:0]});
    check("resume_full", count, 200);
    send(1'b1, 32'h0004_ffff);
    check("resume_ovf", overflow, 1);

    // start has priority over a same-cycle write, free and read
    start    = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_dat   = 32'h0009_0009;
    rd_free  = 1'b1;
    rd_en    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rd_free  = 1'b0;
    rd_en    = 1'b0;
    check("start_cnt", count, 0);
    check("start_ovf", overflow, 0);
    check("start_rdvld", rd_valid, 0);
    check("start_full", full, 0);
    check("start_symdone", sym_done, 0);

    rd_free = 1'b1;
    tick();
    rd_free = 1'b0;
    check("free_empty", count, 0);

    send_sym(5, p);
    check("sym5_cnt", count, 200);
    check("sym5_sd", p, 1);
    read_chk("sym5_off0", 8'd0, ent(5, 0));
    read_chk("sym5_off150", 8'd150, ent(5, 150));
    read_chk("sym5_off199", 8'd199, ent(5, 199));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
